// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg                                                             |
// | Shared segment constants, FSM encoding and decimal bound helper.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_ENCODE = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SHIFT  = ST_SHIFT,
      ENCODE = ST_ENCODE
   } state_t;

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 32'd10;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_digit_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_digit_lut                                                       |
// | BCD digit to active-low 7-segment pattern (g..a); 10-15 are dark.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_digit_lut
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = 7'b1000000;
         4'd1:    seg_o = 7'b1111001;
         4'd2:    seg_o = 7'b0100100;
         4'd3:    seg_o = 7'b0110000;
         4'd4:    seg_o = 7'b0011001;
         4'd5:    seg_o = 7'b0010010;
         4'd6:    seg_o = 7'b0000010;
         4'd7:    seg_o = 7'b1111000;
         4'd8:    seg_o = 7'b0000000;
         4'd9:    seg_o = 7'b0010000;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/score_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | score_display_driver                                                 |
// | Binary to DIGITS-digit decimal (double-dabble) driving active-low    |
// | HEX displays. Optional display blinking under macro SEG_BLINK_EN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module score_display_driver
   import seg7_pkg::*;
#(
   parameter int VALUE_W   = 16,
   parameter int DIGITS    = 5,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [VALUE_W-1:0]    value,
   input  logic                  blank_lz,
   input  logic                  blink,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int          BCD_W = 4*DIGITS + 4;
   localparam int          CNT_W = $clog2(VALUE_W + 1);
   localparam logic [31:0] LIMIT = pow10(DIGITS);

   state_t              state_q, state_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic [VALUE_W-1:0]  bin_q, bin_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                blank_q, blank_d;
   logic                ovf_pend_q, ovf_pend_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;
   logic [7*DIGITS-1:0] seg_q, seg_d;

   logic [BCD_W-1:0]    adj;
   logic [7*DIGITS-1:0] lut_seg;
   logic [7*DIGITS-1:0] enc_seg;
   logic [DIGITS-1:0]   lit;
   logic                ovf_now;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         seg7_digit_lut u_lut (
            .bcd_i (bcd_q[4*k +: 4]),
            .seg_o (lut_seg[7*k +: 7])
         );
      end
   endgenerate

   // A digit stays lit if it or any more significant digit is nonzero.
   always_comb begin
      logic any;
      any = 1'b0;
      lit = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         any    = any | (bcd_q[4*k +: 4] != 4'd0);
         lit[k] = any | (k == 0) | ~blank_q;
      end
   end

   // The pending flag covers values too large for the spare nibble to catch.
   assign ovf_now = ovf_pend_q | (|bcd_q[BCD_W-1 -: 4]);

   always_comb begin
      enc_seg = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (ovf_now)     enc_seg[7*k +: 7] = SEG_DASH;
         else if (lit[k]) enc_seg[7*k +: 7] = lut_seg[7*k +: 7];
         else             enc_seg[7*k +: 7] = SEG_BLANK;
      end
   end

   always_comb begin
      state_d    = state_q;
      bcd_d      = bcd_q;
      bin_d      = bin_q;
      cnt_d      = cnt_q;
      blank_d    = blank_q;
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      seg_d      = seg_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               bin_d      = value;
               blank_d    = blank_lz;
               ovf_pend_d = (32'(value) >= LIMIT);
               bcd_d      = '0;
               cnt_d      = CNT_W'(VALUE_W);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ENCODE;
         end
         ENCODE: begin
            seg_d   = enc_seg;
            ovf_d   = ovf_now;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bcd_q      <= '0;
         bin_q      <= '0;
         cnt_q      <= '0;
         blank_q    <= 1'b0;
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         seg_q      <= '1;
      end else begin
         state_q    <= state_d;
         bcd_q      <= bcd_d;
         bin_q      <= bin_d;
         cnt_q      <= cnt_d;
         blank_q    <= blank_d;
         ovf_pend_q <= ovf_pend_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         seg_q      <= seg_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign overflow = ovf_q;

`ifdef SEG_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV + 1);
   logic [BW-1:0] bcnt_q;
   logic          phase_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
         bcnt_q  <= '0;
         phase_q <= ~phase_q;
      end else begin
         bcnt_q  <= bcnt_q + BW'(1);
      end
   end

   assign seg = (blink && phase_q) ? '1 : seg_q;
`else
   localparam int unused_blink_div = BLINK_DIV;
   logic unused_blink;
   assign unused_blink = blink;
   assign seg          = seg_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_score_display_driver                                              |
// | Two configurations (16b/5 digits, 10b/3 digits) against a decimal    |
// | reference model plus hand-computed display patterns.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_score_display_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  load, blank_lz, blink;
   logic [15:0] value0;
   logic [9:0]  value1;
   logic [1:0]  busy, done, overflow;
   logic [34:0] seg0;
   logic [20:0] seg1;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 0;

   score_display_driver #(.VALUE_W(16), .DIGITS(5), .BLINK_DIV(4)) dut0 (
      .clk(clk), .reset(reset), .load(load[0]), .value(value0),
      .blank_lz(blank_lz[0]), .blink(blink[0]), .busy(busy[0]),
      .done(done[0]), .overflow(overflow[0]), .seg(seg0));

   score_display_driver #(.VALUE_W(10), .DIGITS(3), .BLINK_DIV(4)) dut1 (
      .clk(clk), .reset(reset), .load(load[1]), .value(value1),
      .blank_lz(blank_lz[1]), .blink(blink[1]), .busy(busy[1]),
      .done(done[1]), .overflow(overflow[1]), .seg(seg1));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned pw10(input int d);
      int unsigned r = 1;
      for (int k = 0; k < d; k++) r = r * 10;
      return r;
   endfunction

   // Decimal rendering straight from the display rules.
   function automatic logic [63:0] exp_seg(input int unsigned v, input int d, input bit bl);
      logic [6:0] pat [10];
      logic [63:0] r;
      int unsigned pk;
      pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      r  = '0;
      pk = 1;
      for (int k = 0; k < d; k++) begin
         logic [6:0] s;
         if (v >= pw10(d))              s = 7'h3F;
         else if (bl && k > 0 && v < pk) s = 7'h7F;
         else                           s = pat[(v / pk) % 10];
         r[7*k +: 7] = s;
         pk = pk * 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] ones(input int d);
      return (64'd1 << (7*d)) - 64'd1;
   endfunction

   int          DG [2] = '{5, 3};
   int          VW [2] = '{16, 10};
   int          m_left [2];
   int unsigned m_val [2];
   bit          m_bl [2];
   logic [63:0] m_seg [2];
   bit          m_ovf [2];
   bit          m_done [2];
   int          m_bcnt;
   bit          m_phase;

   always @(posedge clk) begin
      if (reset) begin
         started = 1;
         m_bcnt  = 0;
         m_phase = 0;
         for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_seg[i] = ones(DG[i]); m_ovf[i] = 0; m_done[i] = 0;
         end
      end else begin
         if (m_bcnt == 3) begin m_bcnt = 0; m_phase = !m_phase; end
         else m_bcnt++;
         for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            if (m_left[i] == 0 && load[i]) begin
               m_left[i] = VW[i] + 1;
               m_val[i]  = (i == 0) ? int'(value0) : int'(value1);
               m_bl[i]   = blank_lz[i];
            end else if (m_left[i] > 0) begin
               m_left[i]--;
               if (m_left[i] == 0) begin
                  m_seg[i]  = exp_seg(m_val[i], DG[i], m_bl[i]);
                  m_ovf[i]  = (m_val[i] >= pw10(DG[i]));
                  m_done[i] = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            logic [63:0] es, as;
            es = m_seg[i];
`ifdef SEG_BLINK_EN
            if (blink[i] && m_phase) es = ones(DG[i]);
`endif
            as = (i == 0) ? 64'(seg0) : 64'(seg1);
            check($sformatf("seg[%0d]", i), as, es);
            check($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(m_left[i] > 0));
            check($sformatf("done[%0d]", i), 64'(done[i]), 64'(m_done[i]));
            check($sformatf("ovf[%0d]", i), 64'(overflow[i]), 64'(m_ovf[i]));
         end
      end
   end

   // Pulses load for one cycle and returns cycles until done (0 on timeout).
   task automatic run(input int i, input int v, input bit bl, output int lat);
      int n;
      if (i == 0) value0 = v[15:0]; else value1 = v[9:0];
      blank_lz[i] = bl;
      load[i] = 1'b1;
      @(negedge clk);
      load[i] = 1'b0;
      n = 1;
      while (!done[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
      lat = done[i] ? n : 0;
   endtask

   int lat;
   int dones;

   initial begin
      reset = 1'b1; load = '0; blank_lz = '0; blink = '0; value0 = '0; value1 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset seg", 64'(seg0), 64'h7FFFFFFFF);
      check("reset busy/done/ovf", {61'd0, busy[0], done[0], overflow[0]}, 64'd0);

      run(0, 1234, 0, lat);
      check("latency 16b", lat, 18);
      check("1234", 64'(seg0), {29'd0, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});
      @(negedge clk);
      run(0, 1234, 1, lat);
      check("1234 blank", 64'(seg0), {29'd0, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
      @(negedge clk);
      run(0, 0, 1, lat);
      check("0 blank", 64'(seg0), 64'h7FFFFFFC0);

      run(1, 999, 0, lat);
      check("latency 10b", lat, 12);
      check("999", 64'(seg1), {43'd0, {3{7'h10}}});
      check("999 ovf", 64'(overflow[1]), 64'd0);
      @(negedge clk);
      run(1, 1000, 0, lat);
      check("1000", 64'(seg1), {43'd0, {3{7'h3F}}});
      check("1000 ovf", 64'(overflow[1]), 64'd1);
      @(negedge clk);
      run(1, 7, 1, lat);
      @(negedge clk);
      run(1, 1023, 1, lat);

      // Load during conversion is dropped; one cycle after done is accepted.
      value0 = 16'd42; blank_lz[0] = 1'b0; load[0] = 1'b1;
      @(negedge clk);
      load[0] = 1'b0;
      dones = 0;
      repeat (4) @(negedge clk);
      value0 = 16'd77; load[0] = 1'b1;
      @(negedge clk);
      load[0] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done[0]) dones++;
      end
      check("single done", dones, 1);
      check("42 kept", 64'(seg0), {29'd0, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24});
      run(0, 9999, 0, lat);
      @(negedge clk);
      run(0, 77, 0, lat);
      check("77 accepted", 64'(seg0), {29'd0, 7'h40, 7'h40, 7'h40, 7'h78, 7'h78});
      @(negedge clk);
      run(0, 65535, 1, lat);
      @(negedge clk);
      run(0, 10000, 1, lat);

      // Reset in the middle of a conversion.
      value0 = 16'd555; load[0] = 1'b1;
      @(negedge clk);
      load[0] = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("busy after reset", 64'(busy[0]), 64'd0);
      reset = 1'b0;
      dones = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done[0]) dones++;
      end
      check("no done after reset", dones, 0);

      run(0, 31, 0, lat);
      blink = 2'b11;
      repeat (20) @(negedge clk);
      blink = 2'b00;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
